// File: rtl/exe_mem_skid_reg_if.sv
// Valid/ready bus carrying one EXE->MEM entry.
// master drives the entry, slave answers with ready.
interface exe_mem_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
);
  logic              valid;
  logic              ready;
  logic              wb;
  logic              mem_read;
  logic              mem_write;
  logic [DEST_W-1:0] dest;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] val_rm;

  modport master (
    output valid, wb, mem_read, mem_write, dest, alu_res, val_rm,
    input  ready
  );
  modport slave (
    input  valid, wb, mem_read, mem_write, dest, alu_res, val_rm,
    output ready
  );
endinterface

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM stage register with a 2-entry skid buffer, synchronous flush
// and a saturating backpressure cycle counter.
module exe_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  exe_mem_skid_reg_if.slave    up,
  exe_mem_skid_reg_if.master   dn,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);
  typedef struct packed {
    logic              wb;
    logic              mem_read;
    logic              mem_write;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
  } ent_t;

  ent_t main_q, skid_q, main_d, skid_d, in_ent;
  logic main_vld, skid_vld, main_vld_d, skid_vld_d;
  logic accept, pop;

  always_comb begin
    in_ent.wb        = up.wb;
    in_ent.mem_read  = up.mem_read;
    in_ent.mem_write = up.mem_write;
    in_ent.dest      = up.dest;
    in_ent.alu_res   = up.alu_res;
    in_ent.val_rm    = up.val_rm;
  end

  // ready depends only on registered skid state, never on out_ready
  assign up.ready = ~skid_vld;
  assign accept   = up.valid & ~skid_vld;
  assign pop      = main_vld & dn.ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld;
    skid_vld_d = skid_vld;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld) begin
      if (accept) begin
        main_d     = in_ent;
        main_vld_d = 1'b1;
      end
    end else if (pop) begin
      if (skid_vld) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d = in_ent;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q    <= '0;
      skid_q    <= '0;
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      occupancy <= 2'd0;
      stall_cnt <= '0;
    end else begin
      main_q    <= main_d;
      skid_q    <= skid_d;
      main_vld  <= main_vld_d;
      skid_vld  <= skid_vld_d;
      occupancy <= {1'b0, main_vld_d} + {1'b0, skid_vld_d};
      if (main_vld && !dn.ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // control bits are qualified by valid; payload simply holds
  assign dn.valid     = main_vld;
  assign dn.wb        = main_q.wb & main_vld;
  assign dn.mem_read  = main_q.mem_read & main_vld;
  assign dn.mem_write = main_q.mem_write & main_vld;
  assign dn.dest      = main_q.dest;
  assign dn.alu_res   = main_q.alu_res;
  assign dn.val_rm    = main_q.val_rm;
endmodule

// File: doc/exe_mem_skid_reg.md
Name: exe_mem_skid_reg

Overview:
Parametrised EXE->MEM pipeline register carrying write-back/memory control, destination register and the ALU result / Rm value from the execute stage to the memory stage. Unlike a plain free-running stage register, it uses a valid/ready handshake with a 2-entry skid buffer, so backpressure from MEM does not combinationally reach EXE. It also supports a synchronous flush for branch/exception squash and counts backpressure cycles for performance monitoring.

Parameters:
DATA_W, 32, width of alu_res and val_rm paths
DEST_W, 4, width of destination register index
CNT_W, 16, width of stall cycle counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous squash of all held and incoming entries
in_valid  in  1  EXE presents a valid entry
in_ready  out  1  stage can accept an entry this cycle
wb_in  in  1  write-back enable
mem_read_in  in  1  load
mem_write_in  in  1  store
dest_in  in  DEST_W  destination register index
alu_res_in  in  DATA_W  ALU result / address
val_rm_in  in  DATA_W  store data
out_valid  out  1  entry presented to MEM
out_ready  in  1  MEM accepts the entry this cycle
wb_out  out  1  write-back enable, gated by valid
mem_read_out  out  1  load, gated by valid
mem_write_out  out  1  store, gated by valid
dest_out  out  DEST_W  destination index
alu_res_out  out  DATA_W  ALU result
val_rm_out  out  DATA_W  store data
occupancy  out  2  held entries: 0, 1 or 2
stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main slot (drives outputs) and skid slot; each has a valid bit. FIFO order strictly preserved.
- Reset (async, rst=1): both valid bits 0, every output 0 (control, dest, data, occupancy, stall_cnt). in_ready becomes 1 after reset, because the skid slot is empty.
- in_ready = NOT skid_valid, driven from a register and not dependent on out_ready.
- Accept: in_valid AND in_ready. Pop: out_valid AND out_ready. out_valid = main_valid.
- Per cycle, without flush:
  - main empty, accept: entry goes to main. out_valid=1 next cycle (1-cycle latency).
  - main full, pop, skid empty, accept: new entry replaces main.
  - main full, pop, skid empty, no accept: main empties.
  - main full, no pop, accept: entry goes to skid. in_ready=0 next cycle.
  - main full, pop, skid full: skid moves to main and skid empties. No accept is possible this cycle.
  - main full, no pop, skid full: hold everything.
- Control gating: wb_out, mem_read_out and mem_write_out are 0 whenever out_valid=0. dest/data outputs hold their last value when invalid.
- Flush: synchronous, has priority over every transfer.
  - Next cycle: both valid bits 0, gated control outputs 0, occupancy 0.
  - The entry offered in the flush cycle is dropped, even if in_ready=1.
  - A pop in the flush cycle still counts as consumed by MEM.
- occupancy = main_valid + skid_valid, registered.
- stall_cnt increments when out_valid=1 and out_ready=0. It saturates at all-ones and is cleared only by rst.
- rst asserted mid-transfer: all state clears immediately. No partial entry survives.

Test Plan:
1. Reset then stream, out_ready=1: push A (alu_res=0x10, dest=3, wb=1), then B (0x20), C (0x30) on consecutive cycles -> out_valid rises one cycle after A; A, B, C appear on consecutive cycles; in_ready stays 1; occupancy stays 1; stall_cnt=0.
2. Backpressure: out_ready=0, push A then B -> occupancy goes 1 then 2; in_ready=0 after B; C is held by EXE. Then out_ready=1 -> A, B, C delivered in order; stall_cnt equals the number of out_ready=0 cycles with out_valid=1 (2).
3. Flush with 2 entries held plus in_valid=1, D offered -> next cycle out_valid=0, wb_out=mem_read_out=mem_write_out=0, occupancy=0, in_ready=1; D is never output.
4. Store entry (mem_write=1, val_rm=0xDEADBEEF) popped, nothing behind it -> mem_write_out=0 on the following cycle; val_rm_out still reads 0xDEADBEEF.
5. CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds.
6. Async rst pulse between clock edges with occupancy=2 -> all outputs 0 immediately, before the next clk edge; after release, in_ready=1 and a new push behaves as in scenario 1.
